dmem_arbiter: RTL and testbench

- Controller that shares the single-port Data_Memory BRAM (byte write enables, 1-cycle registered read) between two requesters: port 0 (CPU load/store unit) and port 1 (program/data loader or debug).
- Handles round-robin arbitration, byte/half/word store lane generation, sub-word load extraction with sign/zero extension, and alignment/range checking.
- Sits between the EX/MEM stage and the Data_Memory instance.

---
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/controller in front of the single-port Data_Memory BRAM.
// Define DMEM_OREG_EN when the BRAM output register is enabled (adds WAIT2).
module dmem_arbiter #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [3:0]  size,
  input  logic [1:0]  sgn,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [3:0]  mem_wea,
  output logic [31:0] mem_addra,
  output logic [31:0] mem_dina,
  input  logic [31:0] mem_douta
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WAIT2, RESP, ERR} state_e;

`ifdef DMEM_OREG_EN
  localparam state_e LAST_WAIT = WAIT2;
`else
  localparam state_e LAST_WAIT = WAIT;
`endif

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        lat_port_q, lat_port_d;
  logic        lat_we_q, lat_we_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic        lat_sgn_q, lat_sgn_d;
  logic [1:0]  lat_off_q, lat_off_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  mem_wea_q, mem_wea_d;
  logic [31:0] mem_addra_q, mem_addra_d;
  logic [31:0] mem_dina_q, mem_dina_d;

  // Granted-port view of the request bus
  logic        gnt_port;
  logic        g_we, g_sgn, g_illegal;
  logic [1:0]  g_size;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  wea_lanes;
  logic [31:0] dina_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    gnt_port  = (req == 2'b11) ? ~last_grant_q : req[1];
    g_we      = gnt_port ? we[1] : we[0];
    g_sgn     = gnt_port ? sgn[1] : sgn[0];
    g_size    = gnt_port ? size[3:2] : size[1:0];
    g_addr    = gnt_port ? addr[63:32] : addr[31:0];
    g_wdata   = gnt_port ? wdata[63:32] : wdata[31:0];
    g_illegal = (g_size == 2'b11)
             || (g_size == 2'b01 && g_addr[0])
             || (g_size == 2'b10 && g_addr[1:0] != 2'b00)
             || (g_addr[31:DEPTH_LOG2+2] != '0);
  end

  always_comb begin
    wea_lanes  = 4'b0000;
    dina_lanes = g_wdata;
    case (g_size)
      2'b00: begin
        wea_lanes  = 4'b0001 << g_addr[1:0];
        dina_lanes = {4{g_wdata[7:0]}};
      end
      2'b01: begin
        wea_lanes  = g_addr[1] ? 4'b1100 : 4'b0011;
        dina_lanes = {2{g_wdata[15:0]}};
      end
      2'b10:   wea_lanes = 4'b1111;
      default: wea_lanes = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte = mem_douta[8*lat_off_q +: 8];
    ld_half = lat_off_q[1] ? mem_douta[31:16] : mem_douta[15:0];
    case (lat_size_q)
      2'b00:   ld_data = {{24{lat_sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{lat_sgn_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_douta;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lat_port_q   <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_size_q   <= 2'b00;
      lat_sgn_q    <= 1'b0;
      lat_off_q    <= 2'b00;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      rdata_q      <= 32'h0;
      mem_wea_q    <= 4'h0;
      mem_addra_q  <= 32'h0;
      mem_dina_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_port_q   <= lat_port_d;
      lat_we_q     <= lat_we_d;
      lat_size_q   <= lat_size_d;
      lat_sgn_q    <= lat_sgn_d;
      lat_off_q    <= lat_off_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_wea_q    <= mem_wea_d;
      mem_addra_q  <= mem_addra_d;
      mem_dina_q   <= mem_dina_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (|req) state_d = g_illegal ? ERR : ISSUE;
      ISSUE: state_d = lat_we_q ? RESP : WAIT;
`ifdef DMEM_OREG_EN
      WAIT:  state_d = WAIT2;
`else
      WAIT:  state_d = RESP;
`endif
      WAIT2: state_d = RESP;
      RESP:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: each _d is what the next state's cycle shows
  always_comb begin
    last_grant_d = last_grant_q;
    lat_port_d   = lat_port_q;
    lat_we_d     = lat_we_q;
    lat_size_d   = lat_size_q;
    lat_sgn_d    = lat_sgn_q;
    lat_off_d    = lat_off_q;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    rdata_d      = 32'h0;
    mem_wea_d    = 4'h0;
    mem_addra_d  = mem_addra_q;
    mem_dina_d   = mem_dina_q;
    if (state_q == IDLE && |req) begin
      last_grant_d = gnt_port;
      lat_port_d   = gnt_port;
      lat_we_d     = g_we;
      lat_size_d   = g_size;
      lat_sgn_d    = g_sgn;
      lat_off_d    = g_addr[1:0];
      if (g_illegal) begin
        ack_d[gnt_port] = 1'b1;
        err_d[gnt_port] = 1'b1;
      end else begin
        mem_wea_d   = g_we ? wea_lanes : 4'h0;
        mem_addra_d = {2'b00, g_addr[31:2]};
        mem_dina_d  = dina_lanes;
      end
    end else if (state_q == ISSUE && lat_we_q) begin
      ack_d[lat_port_q] = 1'b1;
    end else if (state_q == LAST_WAIT) begin
      ack_d[lat_port_q] = 1'b1;
      rdata_d           = ld_data;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign mem_wea   = mem_wea_q;
  assign mem_addra = mem_addra_q;
  assign mem_dina  = mem_dina_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural Data_Memory and an ack scoreboard.
module tb_dmem_arbiter;

`ifdef DMEM_OREG_EN
  localparam int RD_LAT = 4;
`else
  localparam int RD_LAT = 3;
`endif

  logic        clka = 1'b0;
  logic        rst_n;
  logic [1:0]  req_r, we_r, sgn_r;
  logic [3:0]  size_r;
  logic [63:0] addr_r, wdata_r;
  logic [1:0]  ack, err;
  logic [31:0] rdata;
  logic        busy;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addra, mem_dina, mem_douta;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic        err;
    logic        we;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  always #5 clka = ~clka;

  dmem_arbiter #(.DEPTH_LOG2(10)) dut (
    .clka(clka), .rst_n(rst_n), .req(req_r), .we(we_r), .size(size_r),
    .sgn(sgn_r), .addr(addr_r), .wdata(wdata_r), .ack(ack), .err(err),
    .rdata(rdata), .busy(busy), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  // Data_Memory model: byte write enables, registered read (optionally twice)
  logic [31:0] bram [0:1023];
  logic [31:0] dout_q, dout_q2;
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++)
      if (mem_wea[b]) bram[mem_addra[9:0]][8*b +: 8] <= mem_dina[8*b +: 8];
    dout_q  <= bram[mem_addra[9:0]];
    dout_q2 <= dout_q;
  end
`ifdef DMEM_OREG_EN
  assign mem_douta = dout_q2;
`else
  assign mem_douta = dout_q;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_ack", {30'h0, ack}, 32'h0);
    end else begin
      e = sb.pop_front();
      chk("ack_port", {30'h0, ack}, 32'h1 << e.port);
      chk("err", {31'h0, err[e.port]}, {31'h0, e.err});
      if (!e.we || e.err) chk("rdata", rdata, e.rdata);
      $display("txn port=%0d we=%0d err=%0d rdata=%h", e.port, e.we, err[e.port], rdata);
    end
  endtask

  // Cycle k=0 is the IDLE cycle in which req is already high.
  task automatic run(input int p, input int lat, input logic eerr, input logic [3:0] ewea,
                     input logic [31:0] eaddra, input logic [31:0] edina, input logic w);
    bit seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clka);
      chk("mem_wea", {28'h0, mem_wea}, (k == 1) ? {28'h0, ewea} : 32'h0);
      if (k == 1 && !eerr) begin
        chk("mem_addra", mem_addra, eaddra);
        if (w) chk("mem_dina", mem_dina, edina);
      end
      if (ack != 2'b00) begin
        chk("latency", k, lat);
        pop_check();
        seen = 1;
      end
    end
    if (!seen) chk("ack_timeout", {30'h0, ack}, 32'h1 << p);
    @(posedge clka); #1;
    req_r[p] = 1'b0;
  endtask

  task automatic drive(input int p, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_r[p]          = 1'b1;
    we_r[p]           = w;
    size_r[2*p +: 2]  = sz;
    sgn_r[p]          = sg;
    addr_r[32*p +: 32]  = a;
    wdata_r[32*p +: 32] = wd;
  endtask

  task automatic issue(input int p, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic eerr,
                       input logic [31:0] erd, input logic [3:0] ewea, input logic [31:0] edina);
    exp_t e;
    int lat;
    e.port = p; e.err = eerr; e.we = w; e.rdata = erd;
    sb.push_back(e);
    drive(p, w, sz, sg, a, wd);
    lat = eerr ? 1 : (w ? 2 : RD_LAT);
    run(p, lat, eerr, ewea, a >> 2, edina, w);
  endtask

  initial begin
    exp_t e;
    int nack;
    rst_n = 1'b0; req_r = '0; we_r = '0; sgn_r = '0; size_r = '0; addr_r = '0; wdata_r = '0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    chk("rst_ack", {30'h0, ack}, 32'h0);
    chk("rst_err", {30'h0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_wea", {28'h0, mem_wea}, 32'h0);
    chk("rst_addra", mem_addra, 32'h0);
    chk("rst_dina", mem_dina, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clka); #1 rst_n = 1'b1;
    @(posedge clka); #1;

    // Word store then sub-word loads
    issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'hF, 32'hDEADBEEF);
    issue(0, 0, 2'b00, 1, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 4'h0, 32'h0);
    issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h000000DE, 4'h0, 32'h0);
    issue(0, 0, 2'b01, 1, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 4'h0, 32'h0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 4'h0, 32'h0);
    issue(1, 0, 2'b00, 1, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 4'h0, 32'h0);
    issue(1, 0, 2'b01, 0, 32'h10, 32'h0, 0, 32'h0000BEEF, 4'h0, 32'h0);
    // Sub-word stores
    issue(1, 1, 2'b00, 0, 32'h11, 32'h00000055, 0, 32'h0, 4'b0010, 32'h55555555);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD55EF, 4'h0, 32'h0);
    issue(1, 1, 2'b01, 0, 32'h12, 32'h0000ABCD, 0, 32'h0, 4'b1100, 32'hABCDABCD);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hABCD55EF, 4'h0, 32'h0);
    // Illegal requests
    issue(0, 0, 2'b10, 0, 32'h2,    32'h0, 1, 32'h0, 4'h0, 32'h0);
    issue(1, 1, 2'b01, 0, 32'h11,   32'h1234, 1, 32'h0, 4'h0, 32'h0);
    issue(0, 0, 2'b11, 0, 32'h0,    32'h0, 1, 32'h0, 4'h0, 32'h0);
    issue(1, 0, 2'b10, 0, 32'h1000, 32'h0, 1, 32'h0, 4'h0, 32'h0);

    // Reset during ISSUE of a write; requester keeps req high
    e.port = 0; e.err = 0; e.we = 1; e.rdata = 32'h0;
    sb.push_back(e);
    drive(0, 1, 2'b10, 0, 32'h20, 32'h12345678);
    @(negedge clka);
    @(negedge clka);
    chk("issue_wea", {28'h0, mem_wea}, 32'hF);
    chk("issue_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_wea", {28'h0, mem_wea}, 32'h0);
    chk("rst_async_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clka);
    @(negedge clka);
    chk("rst_no_ack", {30'h0, ack}, 32'h0);
    @(posedge clka); #1 rst_n = 1'b1;
    run(0, 2, 0, 4'hF, 32'h8, 32'h12345678, 1);
    issue(1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h12345678, 4'h0, 32'h0);

    // Fresh reset, then both ports request continuously
    rst_n = 1'b0;
    @(posedge clka); #1 rst_n = 1'b1;
    @(posedge clka); #1;
    for (int i = 0; i < 4; i++) begin
      e.port = i % 2; e.err = 0; e.we = 0;
      e.rdata = (i % 2 == 0) ? 32'hABCD55EF : 32'h12345678;
      sb.push_back(e);
    end
    drive(0, 0, 2'b10, 0, 32'h10, 32'h0);
    drive(1, 0, 2'b10, 0, 32'h20, 32'h0);
    nack = 0;
    for (int k = 0; k < 40 && nack < 4; k++) begin
      @(negedge clka);
      if (ack != 2'b00) begin
        pop_check();
        nack++;
      end
    end
    chk("arb_ack_count", nack, 32'd4);
    @(posedge clka); #1 req_r = 2'b00;
    repeat (6) @(negedge clka);
    chk("arb_idle_busy", {31'h0, busy}, 32'h0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
